// File: rtl/gpu_pkg.sv
// Shared 2D GPU definitions: opcode field bounds and the segment selector codes
// used by the controller to step through the segments of a shape.
package gpu_pkg;

  localparam int LOC_W    = 19;
  localparam int OPCODE_W = 76;
  localparam int PAIR_W   = 2 * LOC_W;

  localparam int LOC1_HI  = 75;
  localparam int LOC1_LO  = 57;
  localparam int LOC2_HI  = 56;
  localparam int LOC2_LO  = 38;
  localparam int LOC3_HI  = 37;
  localparam int LOC3_LO  = 19;
  localparam int FILL_BIT = 18;
  localparam int SPARE_HI = 17;

  typedef enum logic [3:0] {
    SID_L1   = 4'd0,
    SID_TRI1 = 4'd1,
    SID_TRI2 = 4'd2,
    SID_TRI3 = 4'd3,
    SID_CIR1 = 4'd4
  } sid_e;

  typedef logic [LOC_W-1:0] loc_t;

  function automatic logic sid_legal(input logic [3:0] sel);
    return (sel <= SID_CIR1);
  endfunction

endpackage

// File: rtl/shape_splitter_if.sv
// Opcode/selector request and registered location-pair result between the
// shape controller (master) and the splitter (slave).
interface shape_splitter_if;
  import gpu_pkg::*;

  logic [OPCODE_W-1:0] opdata;
  logic [3:0]          output_sel;
  logic                in_valid;
  logic [PAIR_W-1:0]   locations;
  logic                fill;
  logic                out_valid;
  logic                sel_err;

  modport master (
    output opdata, output_sel, in_valid,
    input  locations, fill, out_valid, sel_err
  );

  modport slave (
    input  opdata, output_sel, in_valid,
    output locations, fill, out_valid, sel_err
  );

endinterface

// File: rtl/splitter_mux.sv
// Combinational field selector: picks the {start, end} location pair for one
// shape segment; illegal selectors yield an all-zero result with err set.
module splitter_mux
  import gpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opdata,
  input  logic [3:0]          output_sel,
  output logic [PAIR_W-1:0]   pair,
  output logic                fill,
  output logic                err
);

  loc_t loc1, loc2, loc3;
  logic unused_spare;

  assign loc1 = opdata[LOC1_HI:LOC1_LO];
  assign loc2 = opdata[LOC2_HI:LOC2_LO];
  assign loc3 = opdata[LOC3_HI:LOC3_LO];
  assign unused_spare = ^opdata[SPARE_HI:0];

  always_comb begin
    pair = '0;
    fill = 1'b0;
    err  = 1'b0;
    case (output_sel)
      SID_L1, SID_TRI1, SID_CIR1: pair = {loc1, loc2};
      SID_TRI2:                   pair = {loc2, loc3};
      SID_TRI3:                   pair = {loc1, loc3};
      default:                    err  = 1'b1;
    endcase
    // fill only travels with a legal segment so an error result is fully zeroed
    if (!err) fill = opdata[FILL_BIT];
  end

endmodule

// File: rtl/shape_splitter.sv
// Registered segment splitter: one-cycle latency from an accepted opcode and
// selector to the location pair presented to the rasteriser.
module shape_splitter
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  shape_splitter_if.slave    bus
);

  logic [PAIR_W-1:0] mux_pair;
  logic              mux_fill;
  logic              mux_err;

  logic [PAIR_W-1:0] locations_q;
  logic              fill_q;
  logic              out_valid_q;
  logic              sel_err_q;

  splitter_mux u_mux (
    .opdata     (bus.opdata),
    .output_sel (bus.output_sel),
    .pair       (mux_pair),
    .fill       (mux_fill),
    .err        (mux_err)
  );

  // reset wins over in_valid so a result in flight is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      locations_q <= '0;
      fill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else if (bus.in_valid) begin
      locations_q <= mux_pair;
      fill_q      <= mux_fill;
      out_valid_q <= 1'b1;
      sel_err_q   <= mux_err;
    end
  end

  assign bus.locations = locations_q;
  assign bus.fill      = fill_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_shape_splitter.sv
// Directed and randomised checks of shape_splitter against hand-computed pairs
// and a small reference model of the segment table.
module tb_shape_splitter;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  shape_splitter_if bus ();

  shape_splitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] make_op(input logic [18:0] l1, input logic [18:0] l2,
                                          input logic [18:0] l3, input logic f,
                                          input logic [17:0] spare);
    return {l1, l2, l3, f, spare};
  endfunction

  task automatic check_out(input string tag, input logic [37:0] loc, input logic f,
                           input logic v, input logic e);
    check({tag, ".loc"},   64'(bus.locations), 64'(loc));
    check({tag, ".fill"},  64'(bus.fill),      64'(f));
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, ".err"},   64'(bus.sel_err),   64'(e));
  endtask

  localparam logic [18:0] A = 19'h00123;
  localparam logic [18:0] B = 19'h7FFFF;
  localparam logic [18:0] C = 19'h2AAAA;

  logic [18:0] r1, r2, r3;
  logic        rf;
  logic [17:0] rs;
  logic [3:0]  rsel;
  logic [37:0] exp_loc;
  logic        exp_fill;

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.opdata     = make_op(A, B, C, 1'b1, 18'h3FFFF);
    bus.output_sel = 4'd0;
    tick();
    check_out("reset", 38'h0, 1'b0, 1'b0, 1'b0);

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check_out("idle_after_reset", 38'h0, 1'b0, 1'b0, 1'b0);

    bus.in_valid   = 1'b1;
    bus.output_sel = 4'd0;
    tick();
    check_out("line", {A, B}, 1'b1, 1'b1, 1'b0);

    bus.output_sel = 4'd1;
    tick();
    check_out("tri1", {A, B}, 1'b1, 1'b1, 1'b0);
    bus.output_sel = 4'd2;
    tick();
    check_out("tri2", {B, C}, 1'b1, 1'b1, 1'b0);
    bus.output_sel = 4'd3;
    tick();
    check_out("tri3", {A, C}, 1'b1, 1'b1, 1'b0);

    bus.opdata     = make_op(A, B, C, 1'b0, 18'h0);
    bus.output_sel = 4'd4;
    tick();
    check_out("circle", {A, B}, 1'b0, 1'b1, 1'b0);

    bus.in_valid   = 1'b0;
    bus.opdata     = make_op(C, A, B, 1'b1, 18'h15555);
    bus.output_sel = 4'd2;
    tick();
    check_out("hold1", {A, B}, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("hold2", {A, B}, 1'b0, 1'b1, 1'b0);

    bus.in_valid   = 1'b1;
    bus.opdata     = make_op(A, B, C, 1'b1, 18'h0);
    bus.output_sel = 4'd9;
    tick();
    check_out("illegal9", 38'h0, 1'b0, 1'b1, 1'b1);
    bus.output_sel = 4'd15;
    tick();
    check_out("illegal15", 38'h0, 1'b0, 1'b1, 1'b1);
    bus.output_sel = 4'd5;
    tick();
    check_out("illegal5", 38'h0, 1'b0, 1'b1, 1'b1);
    bus.output_sel = 4'd0;
    tick();
    check_out("recover", {A, B}, 1'b1, 1'b1, 1'b0);

    reset          = 1'b1;
    bus.output_sel = 4'd2;
    tick();
    check_out("reset_prio", 38'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("first_after_reset", {B, C}, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      r1   = 19'($urandom);
      r2   = 19'($urandom);
      r3   = 19'($urandom);
      rf   = 1'($urandom);
      rs   = 18'($urandom);
      rsel = 4'($urandom_range(0, 4));
      case (rsel)
        4'd2:    exp_loc = {r2, r3};
        4'd3:    exp_loc = {r1, r3};
        default: exp_loc = {r1, r2};
      endcase
      exp_fill       = rf;
      bus.opdata     = make_op(r1, r2, r3, rf, rs);
      bus.output_sel = rsel;
      tick();
      check_out("rand", exp_loc, exp_fill, 1'b1, 1'b0);
      // same fields, inverted spare: result must not move
      if ((i % 8) == 0) begin
        bus.opdata = make_op(r1, r2, r3, rf, ~rs);
        tick();
        check_out("spare", exp_loc, exp_fill, 1'b1, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shape_splitter.md
# shape_splitter

Registered field selector in the 2D GPU drawing path: takes a 76-bit shape opcode plus a segment selector and presents the two 19-bit locations the downstream line or circle rasteriser needs for that segment. Sits between the opcode decoder/controller, which steps through the segments of a shape, and the rasteriser datapath.

## Interface
Parameters: none; widths are fixed by the opcode format.

- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high reset
- opdata  in  76  shape opcode: [75:57] loc1, [56:38] loc2, [37:19] loc3, [18] fill, [17:0] spare (ignored)
- output_sel  in  4  segment selector (SID code)
- in_valid  in  1  opdata/output_sel are valid this cycle
- locations  out  38  selected pair {start[37:19], end[18:0]}
- fill  out  1  opdata[18] registered alongside locations
- out_valid  out  1  locations/fill hold a result
- sel_err  out  1  registered flag: the last accepted output_sel was not a legal code

## Operation
- SID codes and the pair each selects:
  - L1 = 0: line, {loc1, loc2}
  - TRI1 = 1: triangle edge 1, {loc1, loc2}
  - TRI2 = 2: triangle edge 2, {loc2, loc3}
  - TRI3 = 3: triangle edge 3, {loc1, loc3}
  - CIR1 = 4: circle, {loc1 (centre), loc2 (radius point)}
- Codes 5–15 are illegal. An illegal code accepted with in_valid=1 gives locations = 0, fill = 0, sel_err = 1, out_valid = 1.
- Fields are copied bit-exact. No arithmetic, sign handling or reordering of the two locations.
- Spare bits never affect any output.
- When in_valid = 0, all outputs hold their previous values. out_valid also holds, so it stays 1 after the first accepted input until reset.

## Timing
- One-cycle latency: inputs sampled at rising edge N with in_valid = 1 appear on all outputs after edge N, and stay until the next accepted input.
- Back-to-back acceptance every cycle is supported; there is no backpressure and no stall.
- Reset is synchronous: on any edge with reset = 1, locations = 0, fill = 0, out_valid = 0, sel_err = 0.
- Reset has priority over in_valid on the same edge. A result in flight is discarded.
- After reset deasserts, the first in_valid edge produces the first out_valid = 1.
- The triangle sequence TRI1 → TRI2 → TRI3 on consecutive cycles with the same opdata must give the three edges on three consecutive cycles.

## Structure
- Shared package gpu_pkg holds:
  - the SID enum (4-bit: L1, TRI1, TRI2, TRI3, CIR1)
  - localparams for the field bounds of loc1/loc2/loc3/fill
  - LOC_W = 19
  - OPCODE_W = 76
- One combinational sub-module, splitter_mux, maps (opdata, output_sel) to (pair, fill, err). The top level adds only the output register stage with reset and in_valid enable.

## Test plan
- Reset: assert reset with in_valid = 1 → after the edge, locations = 0, fill = 0, out_valid = 0, sel_err = 0.
- Line: loc1 = 19'h00123, loc2 = 19'h7FFFF, loc3 = 19'h2AAAA, fill = 1, sel = L1 → next cycle locations = {19'h00123, 19'h7FFFF}, fill = 1, out_valid = 1.
- Triangle: same opdata, sel = TRI1, TRI2, TRI3 on consecutive cycles → {123, 7FFFF}, then {7FFFF, 2AAAA}, then {123, 2AAAA}, one per cycle.
- Circle and hold: sel = CIR1 → {loc1, loc2}. Then drop in_valid and change opdata → outputs unchanged.
- Illegal select: sel = 4'd9 → locations = 0, sel_err = 1. Then a legal sel = L1 → sel_err returns to 0.
- Randomised: 1000 iterations over random loc1/loc2/loc3/spare and sel in 0–4, checked against a model one cycle later. Spare values must never change the result.
